// File: rtl/cntr_pkg.sv
// cntr_pkg: shared types and helpers for the cntr_bank counter block.
//   step_e    - per-channel next-state decision, one value per clock
//   cnt_max() - all-ones value of a counter of the given width
//   CNT_ZERO  - zero value, used by channels for the low limit
package cntr_pkg;

    typedef enum logic [2:0] {
        HOLD    = 3'd0,
        LOAD    = 3'd1,
        INC     = 3'd2,
        DEC     = 3'd3,
        WRAP_HI = 3'd4,
        WRAP_LO = 3'd5,
        SAT     = 3'd6
    } step_e;

    localparam logic [15:0] CNT_ZERO = 16'd0;

    // Upper limit of a width-bit counter (width limited to 16).
    function automatic logic [15:0] cnt_max(input int width);
        return 16'((32'd1 << width) - 32'd1);
    endfunction

endpackage

// File: rtl/cntr_chan.sv
// cntr_chan: one WIDTH-bit up/down counter channel with wrap or saturate mode.
// Ports:
//   clk, rst          - clock and synchronous active-high reset
//   tick              - shared prescaler tick (step permission)
//   en, dir, sat_mode - enable, direction (1 = up), saturate (1) or wrap (0)
//   load, load_val    - synchronous load strobe and value (beats a tick)
//   cnt, tc, sat      - registered count, one-cycle terminal pulse, sticky flag
module cntr_chan
    import cntr_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             en,
    input  logic             dir,
    input  logic             sat_mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             sat
);

    localparam logic [WIDTH-1:0] MAX_C    = WIDTH'(cnt_max(WIDTH));
    localparam logic [WIDTH-1:0] ZERO_C   = WIDTH'(CNT_ZERO);
    localparam logic [WIDTH-1:0] ONE_C    = WIDTH'(1);
    localparam logic [WIDTH-1:0] MAX_M1_C = MAX_C - ONE_C;

    logic [WIDTH-1:0] cnt_r;
    logic             tc_r;
    logic             sat_r;
    step_e            step_s;
    logic [WIDTH-1:0] cnt_nxt_s;
    logic             tc_nxt_s;
    logic             sat_nxt_s;

    // Decide this cycle's action: load beats a tick; dir/sat_mode matter only on a tick.
    always_comb begin
        step_s = HOLD;
        if (load) begin
            step_s = LOAD;
        end else if (tick && en) begin
            if (dir) begin
                if (cnt_r == MAX_C) begin
                    step_s = sat_mode ? SAT : WRAP_HI;
                end else begin
                    step_s = INC;
                end
            end else begin
                if (cnt_r == ZERO_C) begin
                    step_s = sat_mode ? SAT : WRAP_LO;
                end else begin
                    step_s = DEC;
                end
            end
        end else begin
            step_s = HOLD;
        end
    end

    // Next count/flags; tc defaults low so it is only ever a single-cycle pulse.
    always_comb begin
        cnt_nxt_s = cnt_r;
        tc_nxt_s  = 1'b0;
        sat_nxt_s = sat_r;
        case (step_s)
            LOAD: begin
                cnt_nxt_s = load_val;
                sat_nxt_s = 1'b0;
            end
            INC: begin
                cnt_nxt_s = cnt_r + ONE_C;
                // In saturate mode, reaching the limit itself is the terminal event.
                tc_nxt_s  = sat_mode && (cnt_r == MAX_M1_C);
            end
            DEC: begin
                cnt_nxt_s = cnt_r - ONE_C;
                tc_nxt_s  = sat_mode && (cnt_r == ONE_C);
            end
            WRAP_HI: begin
                cnt_nxt_s = ZERO_C;
                tc_nxt_s  = 1'b1;
            end
            WRAP_LO: begin
                cnt_nxt_s = MAX_C;
                tc_nxt_s  = 1'b1;
            end
            SAT: begin
                sat_nxt_s = 1'b1;
            end
            HOLD: begin
                cnt_nxt_s = cnt_r;
            end
            default: begin
                cnt_nxt_s = cnt_r;
                tc_nxt_s  = 1'b0;
                sat_nxt_s = sat_r;
            end
        endcase
    end

    // Channel state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= ZERO_C;
            tc_r  <= 1'b0;
            sat_r <= 1'b0;
        end else begin
            cnt_r <= cnt_nxt_s;
            tc_r  <= tc_nxt_s;
            sat_r <= sat_nxt_s;
        end
    end

    assign cnt = cnt_r;
    assign tc  = tc_r;
    assign sat = sat_r;

endmodule

// File: rtl/cntr_bank.sv
// cntr_bank: NCH independent WIDTH-bit counters sharing one programmable prescaler.
// Ports:
//   wb_clk_i, wb_rst_i  - clock, synchronous active-high reset
//   presc_div_i         - common tick every presc_div_i+1 clocks
//   en_i/dir_i/sat_i    - per-channel enable, direction (1 = up), saturate mode
//   load_i, load_val_i  - per-channel load strobe, values packed k*WIDTH +: WIDTH
//   cnt_o               - registered counts, same packing as load_val_i
//   tc_o, sat_o         - per-channel terminal-count pulse and sticky limit flag
module cntr_bank
    import cntr_pkg::*;
#(
    parameter int NCH   = 2,
    parameter int WIDTH = 4,
    parameter int PW    = 8
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic [PW-1:0]        presc_div_i,
    input  logic [NCH-1:0]       en_i,
    input  logic [NCH-1:0]       dir_i,
    input  logic [NCH-1:0]       sat_i,
    input  logic [NCH-1:0]       load_i,
    input  logic [NCH*WIDTH-1:0] load_val_i,
    output logic [NCH*WIDTH-1:0] cnt_o,
    output logic [NCH-1:0]       tc_o,
    output logic [NCH-1:0]       sat_o
);

    logic [PW-1:0] pc_r;
    logic          tick_s;

    // Tick on ">=" rather than "==" so lowering the divider below pc ticks at once
    // instead of stalling for a full 2^PW roll-over.
    always_comb begin
        if (pc_r >= presc_div_i) begin
            tick_s = 1'b1;
        end else begin
            tick_s = 1'b0;
        end
    end

    // Shared free-running prescaler counter; never gated by channel enables.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            pc_r <= PW'(0);
        end else if (tick_s) begin
            pc_r <= PW'(0);
        end else begin
            pc_r <= pc_r + PW'(1);
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_chan
        cntr_chan #(
            .WIDTH(WIDTH)
        ) u_chan (
            .clk      (wb_clk_i),
            .rst      (wb_rst_i),
            .tick     (tick_s),
            .en       (en_i[k]),
            .dir      (dir_i[k]),
            .sat_mode (sat_i[k]),
            .load     (load_i[k]),
            .load_val (load_val_i[k*WIDTH +: WIDTH]),
            .cnt      (cnt_o[k*WIDTH +: WIDTH]),
            .tc       (tc_o[k]),
            .sat      (sat_o[k])
        );
    end

endmodule

// File: tb/tb_cntr_bank.sv
// tb_cntr_bank: directed stimulus with a cycle-tagged expectation queue; a
// negedge monitor pops and compares each expectation in its target cycle.
module tb_cntr_bank;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] presc;
    logic [1:0] en, dir, sat_m, load;
    logic [7:0] lv;
    logic [7:0] cnt;
    logic [1:0] tc, sat;

    typedef struct {
        int         cyc;
        int         tag;
        logic [7:0] cnt;
        logic [1:0] tc;
        logic [1:0] sat;
        logic [1:0] mask;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    bit   done   = 1'b0;

    cntr_bank #(.NCH(2), .WIDTH(4), .PW(8)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .presc_div_i (presc),
        .en_i        (en),
        .dir_i       (dir),
        .sat_i       (sat_m),
        .load_i      (load),
        .load_val_i  (lv),
        .cnt_o       (cnt),
        .tc_o        (tc),
        .sat_o       (sat)
    );

    // Clock generation.
    always #5 clk = ~clk;

    // Edge counter used to tag expectations with their target cycle.
    always @(posedge clk) cyc <= cyc + 1;

    // Queue the state expected right after the next rising edge.
    task automatic push(input int tag, input logic [3:0] c0, input logic t0, input logic s0,
                        input logic [3:0] c1, input logic t1, input logic s1, input logic [1:0] m);
        exp_t e;
        e.cyc  = cyc + 1;
        e.tag  = tag;
        e.cnt  = {c1, c0};
        e.tc   = {t1, t0};
        e.sat  = {s1, s0};
        e.mask = m;
        q.push_back(e);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare each expectation in its cycle, then summarise when stimulus is done.
    always @(negedge clk) begin
        logic [7:0] cm;
        if (q.size() > 0 && q[0].cyc < cyc) begin
            mon_e = q.pop_front();
            checks++;
            errors++;
            $display("FAIL stale tag%0d target cyc %0d now %0d", mon_e.tag, mon_e.cyc, cyc);
        end
        if (q.size() > 0 && q[0].cyc == cyc) begin
            mon_e = q.pop_front();
            cm = {{4{mon_e.mask[1]}}, {4{mon_e.mask[0]}}};
            checks++;
            if ((((cnt ^ mon_e.cnt) & cm) != 8'd0) ||
                (((tc ^ mon_e.tc) & mon_e.mask) != 2'd0) ||
                (((sat ^ mon_e.sat) & mon_e.mask) != 2'd0)) begin
                errors++;
                $display("FAIL tag%0d cyc%0d got cnt=%h tc=%b sat=%b want cnt=%h tc=%b sat=%b mask=%b",
                         mon_e.tag, cyc, cnt, tc, sat, mon_e.cnt, mon_e.tc, mon_e.sat, mon_e.mask);
            end
        end
        if (done) begin
            if (q.size() != 0) begin
                checks++;
                errors++;
                $display("FAIL drain %0d expectations left", q.size());
            end
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    // Directed stimulus.
    initial begin
        int   e1;
        logic t1, s1;
        logic en1;

        rst = 1'b1; presc = 8'd0; en = 2'b00; dir = 2'b00; sat_m = 2'b00;
        load = 2'b00; lv = 8'h00;

        // 1: reset, then ch0 up/wrap every cycle: 1..15,0,1..4, tc only at 0.
        push(0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'b11);
        nxt();
        rst = 1'b0; en = 2'b01; dir = 2'b01;
        for (int i = 1; i <= 20; i++) begin
            push(1, 4'(i % 16), (i % 16) == 0, 1'b0, 4'd0, 1'b0, 1'b0, 2'b11);
            nxt();
        end

        // 2: prescaler /4, then drop divider to 0 while pc = 2.
        rst = 1'b1;
        push(20, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'b11);
        nxt();
        rst = 1'b0; presc = 8'd3;
        for (int j = 1; j <= 14; j++) begin
            push(2, 4'(j / 4), 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'b11);
            nxt();
        end
        presc = 8'd0;
        for (int k = 1; k <= 4; k++) begin
            push(21, 4'(3 + k), 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'b11);
            nxt();
        end

        // 3: saturate down from 2, reverse, then reload clears sat.
        load = 2'b01; lv = 8'h02; dir = 2'b00; sat_m = 2'b01;
        push(3, 4'd2, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'b01); nxt();
        load = 2'b00;
        push(3, 4'd1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'b01); nxt();
        push(3, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 2'b01); nxt();
        push(3, 4'd0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 2'b01); nxt();
        push(3, 4'd0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 2'b01); nxt();
        dir = 2'b01;
        push(30, 4'd1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 2'b01); nxt();
        push(30, 4'd2, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 2'b01); nxt();
        load = 2'b01; lv = 8'h05;
        push(31, 4'd5, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'b01); nxt();
        load = 2'b00; en = 2'b00;
        push(31, 4'd5, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'b01); nxt();

        // 4: ch1 at 15; load 0 on a tick that would otherwise wrap with tc.
        load = 2'b10; lv = 8'hF0;
        push(4, 4'd0, 1'b0, 1'b0, 4'd15, 1'b0, 1'b0, 2'b10); nxt();
        en = 2'b10; dir = 2'b10; sat_m = 2'b00; lv = 8'h00;
        push(4, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'b10); nxt();
        load = 2'b00; dir = 2'b00;
        push(40, 4'd0, 1'b0, 1'b0, 4'd15, 1'b1, 1'b0, 2'b10); nxt();
        push(40, 4'd0, 1'b0, 1'b0, 4'd14, 1'b0, 1'b0, 2'b10); nxt();

        // 5: ch0 up/wrap alongside ch1 down/saturate with enable toggling every 5 clocks.
        rst = 1'b1; en = 2'b00;
        push(50, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'b11); nxt();
        rst = 1'b0; en = 2'b11; dir = 2'b01; sat_m = 2'b10; load = 2'b10; lv = 8'h60;
        push(5, 4'd1, 1'b0, 1'b0, 4'd6, 1'b0, 1'b0, 2'b11); nxt();
        load = 2'b00;
        e1 = 6; t1 = 1'b0; s1 = 1'b0;
        for (int i = 2; i <= 40; i++) begin
            en1 = (((i - 2) / 5) % 2) == 0;
            en  = {en1, 1'b1};
            t1  = 1'b0;
            if (en1) begin
                if (e1 > 0) begin
                    e1 = e1 - 1;
                    t1 = (e1 == 0);
                end else begin
                    s1 = 1'b1;
                end
            end
            push(5, 4'(i % 16), (i % 16) == 0, 1'b0, 4'(e1), t1, s1, 2'b11);
            nxt();
        end

        // 6: divide-by-3, reset mid-run at cnt 9 with pc nonzero.
        rst = 1'b1;
        push(60, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'b11); nxt();
        rst = 1'b0; presc = 8'd2; en = 2'b11; dir = 2'b01; sat_m = 2'b10;
        for (int j = 1; j <= 28; j++) begin
            push(6, 4'(j / 3), 1'b0, 1'b0, 4'd0, 1'b0, j >= 3, 2'b11);
            nxt();
        end
        rst = 1'b1;
        push(61, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'b11); nxt();
        rst = 1'b0;
        for (int j = 1; j <= 6; j++) begin
            push(62, 4'(j / 3), 1'b0, 1'b0, 4'd0, 1'b0, j >= 3, 2'b11);
            nxt();
        end

        nxt();
        done = 1'b1;
    end

endmodule
